// File: rtl/sha_sched_pkg.sv
// Shared state encoding and rate-type codes for the SHA/SHAKE core scheduler.
package sha_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_ARM,
        S_RUN,
        S_DONE,
        S_HOLD,
        S_SQZ_RST,
        S_SQZ_GO
    } sched_state_e;

    localparam logic [1:0] RATE_SHA512   = 2'd0;
    localparam logic [1:0] RATE_SHA256   = 2'd1;
    localparam logic [1:0] RATE_SHAKE128 = 2'd2;

endpackage

// File: rtl/sha_shake_scheduler_if.sv
// Requester-side bus of the SHA/SHAKE scheduler: per-requester job fields, grant and completion.
interface sha_shake_scheduler_if #(
    parameter int NREQ = 3
);
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0][1:0]  req_rate_type;
    logic [NREQ-1:0][31:0] req_mlen;
    logic [NREQ-1:0][31:0] req_olen;
    logic [NREQ-1:0]       req_more;
    logic [NREQ-1:0]       req_release;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       job_done;

    modport master (
        output req, req_rate_type, req_mlen, req_olen, req_more, req_release,
        input  gnt, job_done
    );

    modport slave (
        input  req, req_rate_type, req_mlen, req_olen, req_more, req_release,
        output gnt, job_done
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after last_i in circular order.
module rr_arbiter #(
    parameter int NREQ = 3,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   last_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o
);
    logic [IW-1:0] cand;

    // Scan farthest-first so the closest candidate after last_i overwrites the result.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        cand  = '0;
        for (int off = NREQ; off >= 1; off--) begin
            cand = IW'((int'(last_i) + off) % NREQ);
            if (req_i[cand]) begin
                gnt_o       = '0;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end
endmodule

// File: rtl/sha_shake_scheduler.sv
// Round-robin owner scheduler sequencing one shared SHA/SHAKE wrapper.
// Optional watchdog on ARM/RUN enabled by defining SHA_SCHED_WATCHDOG_EN.
module sha_shake_scheduler
    import sha_sched_pkg::*;
#(
    parameter int NREQ        = 3,
    parameter int WDOG_CYCLES = 4096
) (
    input  logic                    clk,
    input  logic                    rst_n,
    sha_shake_scheduler_if.slave    rq,
    output logic [$clog2(NREQ)-1:0] owner_o,
    output logic                    busy_o,
    output logic                    err_o,
    output logic                    core_rst_o,
    output logic                    core_intermediate_rst_o,
    output logic                    core_next_extract_o,
    output logic [1:0]              core_rate_type_o,
    output logic [31:0]             core_mlen_o,
    output logic [31:0]             core_olen_o,
    input  logic                    core_done_i
);
    localparam int IW = $clog2(NREQ);

    sched_state_e    state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [1:0]      rate_q,  rate_d;
    logic [31:0]     mlen_q,  mlen_d;
    logic [31:0]     olen_q,  olen_d;
    logic [NREQ-1:0] arb_oh;
    logic [IW-1:0]   arb_idx;
    logic [NREQ-1:0] owner_oh;
    logic            wdog_pulse;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req_i  (rq.req),
        .last_i (owner_q),
        .gnt_o  (arb_oh),
        .idx_o  (arb_idx)
    );

`ifdef SHA_SCHED_WATCHDOG_EN
    localparam logic [31:0] WDOG_LIM = 32'(WDOG_CYCLES - 1);
    logic [31:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        wto_q, wto_d;
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rate_d  = rate_q;
        mlen_d  = mlen_q;
        olen_d  = olen_q;
        case (state_q)
            S_IDLE: begin
                if (|arb_oh) begin
                    owner_d = arb_idx;
                    rate_d  = rq.req_rate_type[arb_idx];
                    mlen_d  = rq.req_mlen[arb_idx];
                    olen_d  = rq.req_olen[arb_idx];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE:   state_d = S_ARM;
            // Wait out the wrapper's stale registered done before watching for the real one.
            S_ARM:     if (!core_done_i) state_d = S_RUN;
            S_RUN:     if (core_done_i) state_d = S_DONE;
            S_DONE:    state_d = S_HOLD;
            S_HOLD: begin
                if (rq.req_release[owner_q]) begin
                    state_d = S_IDLE;
                end else if (rq.req_more[owner_q] && rate_q == RATE_SHAKE128) begin
                    olen_d  = rq.req_olen[owner_q];
                    state_d = S_SQZ_RST;
                end
            end
            S_SQZ_RST: state_d = S_SQZ_GO;
            S_SQZ_GO:  state_d = S_ARM;
            default:   state_d = S_IDLE;
        endcase
`ifdef SHA_SCHED_WATCHDOG_EN
        cnt_d = cnt_q;
        err_d = err_q;
        wto_d = 1'b0;
        if (state_q == S_ARM || state_q == S_RUN) begin
            if (cnt_q == WDOG_LIM) begin
                err_d   = 1'b1;
                wto_d   = 1'b1;
                state_d = S_IDLE;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
        end else if (state_d == S_ARM) begin
            cnt_d = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            owner_q <= IW'(NREQ - 1);
            rate_q  <= '0;
            mlen_q  <= '0;
            olen_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rate_q  <= rate_d;
            mlen_q  <= mlen_d;
            olen_q  <= olen_d;
        end
    end

`ifdef SHA_SCHED_WATCHDOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
            wto_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
            wto_q <= wto_d;
        end
    end
    assign wdog_pulse = wto_q;
    assign err_o      = err_q;
`else
    assign wdog_pulse = 1'b0;
    assign err_o      = 1'b0;
`endif

    // A watchdog abort lands in IDLE while owner_q still names the aborted requester.
    assign owner_oh = NREQ'(1) << owner_q;

    always_comb begin
        rq.gnt      = (state_q != S_IDLE) ? owner_oh : '0;
        rq.job_done = (state_q == S_DONE || wdog_pulse) ? owner_oh : '0;
    end

    assign owner_o                 = owner_q;
    assign busy_o                  = (state_q != S_IDLE);
    assign core_rst_o              = (state_q == S_IDLE) || (state_q == S_ISSUE);
    assign core_intermediate_rst_o = (state_q == S_SQZ_RST);
    assign core_next_extract_o     = (state_q == S_SQZ_GO);
    assign core_rate_type_o        = rate_q;
    assign core_mlen_o             = mlen_q;
    assign core_olen_o             = olen_q;
endmodule

// File: tb/tb_sha_shake_scheduler.sv
// Directed bench for sha_shake_scheduler with a wrapper model and a job_done scoreboard.
// Watchdog steps run only when SHA_SCHED_WATCHDOG_EN is defined.
module tb_sha_shake_scheduler;
    localparam int NREQ = 3;
`ifdef SHA_SCHED_WATCHDOG_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 120;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [1:0]  owner;
    logic        busy, err, core_rst, core_irst, core_nx, core_done;
    logic [1:0]  core_rate;
    logic [31:0] core_mlen, core_olen;

    sha_shake_scheduler_if #(.NREQ(NREQ)) bus ();

    sha_shake_scheduler #(.NREQ(NREQ), .WDOG_CYCLES(16)) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .rq                      (bus),
        .owner_o                 (owner),
        .busy_o                  (busy),
        .err_o                   (err),
        .core_rst_o              (core_rst),
        .core_intermediate_rst_o (core_irst),
        .core_next_extract_o     (core_nx),
        .core_rate_type_o        (core_rate),
        .core_mlen_o             (core_mlen),
        .core_olen_o             (core_olen),
        .core_done_i             (core_done)
    );

    int errors = 0;
    int checks = 0;
    int done_cnt [NREQ];
    logic [1:0] exp_q [$];
    bit hang = 1'b0;
    int wcnt;

    // Wrapper model: registered done rises LAT cycles after it starts running.
    always @(posedge clk) begin
        if (core_rst || core_irst || core_nx) begin
            core_done <= 1'b0;
            wcnt      <= 0;
        end else if (!core_done && !hang) begin
            if (wcnt == LAT - 1) core_done <= 1'b1;
            else                 wcnt      <= wcnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.job_done !== 3'b000) begin
            for (int i = 0; i < NREQ; i++) if (bus.job_done[i]) done_cnt[i]++;
            if (exp_q.size() == 0) begin
                check("unexpected_job_done", 32'(bus.job_done), 32'd0);
            end else begin
                logic [1:0] e;
                e = exp_q.pop_front();
                check("job_done_order", 32'(bus.job_done), 32'(3'(1) << e));
            end
        end
    end

    task automatic start_job(input logic [1:0] idx, input logic [1:0] rate,
                             input logic [31:0] mlen, input logic [31:0] olen);
        bus.req_rate_type[idx] = rate;
        bus.req_mlen[idx]      = mlen;
        bus.req_olen[idx]      = olen;
        bus.req[idx]           = 1'b1;
        exp_q.push_back(idx);
    endtask

    task automatic wait_gnt(input logic [1:0] idx);
        int n = 0;
        while (bus.gnt === 3'b000 && n < 20) begin @(negedge clk); n++; end
        check("gnt_onehot", 32'(bus.gnt), 32'(3'(1) << idx));
    endtask

    task automatic wait_done(input logic [1:0] idx);
        int n = 0;
        while (bus.job_done[idx] !== 1'b1 && n < LAT + 60) begin @(negedge clk); n++; end
        check("job_done_seen", 32'(bus.job_done[idx]), 32'd1);
    endtask

    task automatic release_job(input logic [1:0] idx);
        bus.req_release[idx] = 1'b1;
        @(negedge clk);
        bus.req_release[idx] = 1'b0;
        check("release_idle_busy", 32'(busy), 32'd0);
        check("release_idle_gnt", 32'(bus.gnt), 32'd0);
    endtask

    task automatic finish_job(input logic [1:0] idx);
        wait_gnt(idx);
        bus.req[idx] = 1'b0;
        wait_done(idx);
        @(negedge clk);
        release_job(idx);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst_n = 1'b0;
        bus.req = '0; bus.req_more = '0; bus.req_release = '0;
        bus.req_rate_type = '0; bus.req_mlen = '0; bus.req_olen = '0;
        repeat (2) @(negedge clk);
        check("rst_core_rst", 32'(core_rst), 32'd1);
        check("rst_gnt", 32'(bus.gnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_owner", 32'(owner), 32'd2);
        check("rst_sqz", {30'd0, core_irst, core_nx}, 32'd0);
        check("rst_mlen", core_mlen, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // req0 and req2 together; first grant carries the latency checks
        start_job(2'd0, 2'd1, 32'd64, 32'd32);
        start_job(2'd2, 2'd0, 32'd72, 32'd64);
        @(negedge clk);
        check("lat_gnt0", 32'(bus.gnt), 32'b001);
        check("lat_core_rst_hi", 32'(core_rst), 32'd1);
        check("lat_owner", 32'(owner), 32'd0);
        check("lat_mlen", core_mlen, 32'd64);
        check("lat_olen", core_olen, 32'd32);
        check("lat_rate", 32'(core_rate), 32'd1);
        bus.req[0] = 1'b0;
        @(negedge clk);
        check("lat_core_rst_lo", 32'(core_rst), 32'd0);
        wait_done(2'd0);
        @(negedge clk);
        check("hold_gnt", 32'(bus.gnt), 32'b001);
        release_job(2'd0);
        finish_job(2'd2);

        // single SHA-256 job
        start_job(2'd0, 2'd1, 32'd64, 32'd32);
        finish_job(2'd0);
        repeat (3) @(negedge clk);
        check("single_done_count", 32'(done_cnt[0]), 32'd2);

        // circular fairness after owner 0
        start_job(2'd1, 2'd1, 32'd10, 32'd32);
        start_job(2'd0, 2'd0, 32'd20, 32'd64);
        finish_job(2'd1);
        finish_job(2'd0);

        // SHAKE128 with two extra squeeze blocks
        start_job(2'd1, 2'd2, 32'd34, 32'd168);
        wait_gnt(2'd1);
        bus.req[1] = 1'b0;
        wait_done(2'd1);
        @(negedge clk);
        for (int r = 0; r < 2; r++) begin
            bus.req_olen[1] = 32'd168 + 32'(r);
            bus.req_more[1] = 1'b1;
            exp_q.push_back(2'd1);
            @(negedge clk);
            check("sqz_irst", {30'd0, core_irst, core_nx}, 32'b10);
            check("sqz_olen", core_olen, 32'd168 + 32'(r));
            bus.req_more[1] = 1'b0;
            @(negedge clk);
            check("sqz_nx", {30'd0, core_irst, core_nx}, 32'b01);
            @(negedge clk);
            check("sqz_arm", {29'd0, core_irst, core_nx, core_rst}, 32'd0);
            check("sqz_arm_busy", 32'(busy), 32'd1);
            wait_done(2'd1);
            @(negedge clk);
        end
        release_job(2'd1);
        check("sqz_done_count", 32'(done_cnt[1]), 32'd4);

        // more on a SHA3-256 job and non-owner release are ignored
        start_job(2'd2, 2'd1, 32'd16, 32'd32);
        wait_gnt(2'd2);
        bus.req[2] = 1'b0;
        wait_done(2'd2);
        @(negedge clk);
        bus.req_more[2] = 1'b1;
        @(negedge clk);
        check("more_sha_irst", 32'(core_irst), 32'd0);
        check("more_sha_gnt", 32'(bus.gnt), 32'b100);
        bus.req_more[2] = 1'b0;
        @(negedge clk);
        check("more_sha_nx", 32'(core_nx), 32'd0);
        bus.req_release[0] = 1'b1;
        @(negedge clk);
        bus.req_release[0] = 1'b0;
        check("nonowner_release_busy", 32'(busy), 32'd1);
        release_job(2'd2);

        // release wins over simultaneous more
        start_job(2'd2, 2'd2, 32'd16, 32'd168);
        wait_gnt(2'd2);
        bus.req[2] = 1'b0;
        wait_done(2'd2);
        @(negedge clk);
        bus.req_more[2] = 1'b1;
        bus.req_release[2] = 1'b1;
        @(negedge clk);
        bus.req_more[2] = 1'b0;
        bus.req_release[2] = 1'b0;
        check("rel_more_busy", 32'(busy), 32'd0);
        check("rel_more_irst", 32'(core_irst), 32'd0);
        @(negedge clk);
        check("rel_more_nx", {30'd0, core_nx, busy}, 32'd0);

        // asynchronous reset during RUN
        bus.req[0] = 1'b1;
        wait_gnt(2'd0);
        bus.req[0] = 1'b0;
        repeat (LAT / 2) @(negedge clk);
        check("run_before_rst", {30'd0, busy, core_rst}, 32'b10);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_core_rst", 32'(core_rst), 32'd1);
        check("midrst_gnt", 32'(bus.gnt), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_owner", 32'(owner), 32'd2);
        check("midrst_mlen", core_mlen, 32'd0);
        check("midrst_olen", core_olen, 32'd0);
        check("midrst_done", 32'(bus.job_done), 32'd0);
        rst_n = 1'b1;
        repeat (LAT + 20) @(negedge clk);
        check("midrst_no_done", 32'(done_cnt[0]), 32'd3);
        start_job(2'd1, 2'd1, 32'd8, 32'd32);
        finish_job(2'd1);

`ifdef SHA_SCHED_WATCHDOG_EN
        hang = 1'b1;
        bus.req[0] = 1'b1;
        exp_q.push_back(2'd0);
        wait_gnt(2'd0);
        bus.req[0] = 1'b0;
        @(negedge clk);
        check("wdog_arm", 32'(core_rst), 32'd0);
        repeat (15) @(negedge clk);
        check("wdog_early", {30'd0, err, bus.job_done[0]}, 32'd0);
        @(negedge clk);
        check("wdog_err", 32'(err), 32'd1);
        check("wdog_pulse", 32'(bus.job_done), 32'b001);
        check("wdog_idle", {30'd0, busy, core_rst}, 32'b01);
        hang = 1'b0;
        start_job(2'd1, 2'd1, 32'd8, 32'd32);
        finish_job(2'd1);
        check("wdog_err_sticky", 32'(err), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("wdog_err_cleared", 32'(err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
`endif

        repeat (3) @(negedge clk);
        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sha_shake_scheduler.md
# sha_shake_scheduler

Round-robin scheduler that shares one SHA/SHAKE wrapper (Keccak core plus its BRAM address generators) between up to NREQ requesters, such as the matrix-generation, secret-sampling and hash-of-public-key units. For each job it latches the requester's parameters, sequences the wrapper's reset, squeeze-continue and extract controls, and waits for the wrapper's `done`. It then either releases the core or runs further SHAKE squeeze blocks for the same owner. The `owner` output drives the top-level BRAM port mux.

## Interface
- NREQ, 3 — number of requesters, 2..8
- WDOG_CYCLES, 4096 — watchdog limit in cycles, used only with the watchdog macro
- clk  in  1  — single clock
- rst_n  in  1  — asynchronous, active-low reset
- req  in  NREQ  — per-requester job request; level, held until `gnt` is seen
- req_rate_type  in  2*NREQ  — slice i = rate type of requester i (0 = SHA3-512, 1 = SHA3-256, 2 = SHAKE128)
- req_mlen  in  32*NREQ  — message length in bytes
- req_olen  in  32*NREQ  — output length in bytes for the first block and for each further squeeze
- req_more  in  NREQ  — owner requests another squeeze block
- req_release  in  NREQ  — owner frees the core
- gnt  out  NREQ  — one-hot grant, held from ISSUE until release
- job_done  out  NREQ  — one-cycle pulse to the owner when output is complete
- owner  out  $clog2(NREQ)  — index of the current or last owner
- busy  out  1  — state != IDLE
- err  out  1  — sticky watchdog error flag
- core_rst  out  1  — synchronous active-high reset into the wrapper
- core_intermediate_rst, core_next_extract  out  1 each  — squeeze-continue controls
- core_rate_type  out  2  — latched rate type
- core_mlen, core_olen  out  32 each  — latched lengths
- core_done  in  1  — wrapper's registered `done`

## Operation
- All outputs are Moore outputs decoded from registered state and registered job fields.
- States: IDLE, ISSUE, ARM, RUN, DONE, HOLD, SQZ_RST, SQZ_GO.
- **IDLE**
  - core_rst=1, which holds the wrapper in reset.
  - If any `req` is high, grant the first requester after `owner` in circular order.
  - Latch that requester's rate_type, mlen and olen, update `owner`, and go to ISSUE.
- **ISSUE**: gnt[owner]=1 and core_rst=1; go to ARM.
- **ARM**: core_rst=0; wait for core_done==0, then go to RUN. This masks the wrapper's stale registered `done`.
- **RUN**: wait for core_done==1, then go to DONE.
- **DONE**: job_done[owner]=1 for one cycle; go to HOLD.
- **HOLD**: wrapper is idle in its end state.
  - req_release[owner] → IDLE and gnt cleared. Release wins over a simultaneous `more`.
  - Else req_more[owner] with latched rate_type==2 → latch req_olen slice and go to SQZ_RST.
  - req_more with rate_type 0 or 1 is ignored.
- **SQZ_RST**: core_intermediate_rst=1, which loads the new olen into the wrapper; go to SQZ_GO.
- **SQZ_GO**: core_next_extract=1; go to ARM.
- `req` from non-owners is ignored until IDLE. Releases and `more` from non-owners are ignored.
- Latched fields stay stable from ISSUE through HOLD; `req_*` changes during a job have no effect.

## Timing
- Reset values: core_rst=1; gnt, job_done, busy, err, core_intermediate_rst and core_next_extract = 0; core_rate_type, core_mlen, core_olen = 0; owner = NREQ-1, so requester 0 wins first; state IDLE.
- Grant latency:
  - req high at cycle t in IDLE → gnt and ISSUE at t+1.
  - core_rst falls at t+2.
- Squeeze sequence: HOLD→SQZ_RST at t, SQZ_GO at t+1, ARM at t+2.
  - The wrapper's `done` falls at t+2, so RUN is entered at t+3.
- Minimum gap between jobs: release seen at t → IDLE at t+1, with the next grant at t+2.
- rst_n asserted mid-job: immediate return to reset values. core_rst=1 aborts the wrapper, and no job_done is issued.

## Configuration
- SHA_SCHED_WATCHDOG_EN defined:
  - A 32-bit counter clears on entry to ARM and counts in ARM and RUN.
  - On reaching WDOG_CYCLES-1: set `err` (sticky until rst_n), pulse job_done[owner], and go to IDLE, which reasserts core_rst.
- Undefined: no counter, `err` tied to 0, ARM/RUN wait indefinitely.

## Structure
- Package `sha_sched_pkg`:
  - state enum
  - rate-type constants RATE_SHA512=0, RATE_SHA256=1, RATE_SHAKE128=2
- Sub-module `rr_arbiter`:
  - Combinational round-robin pick from `req` and the previous `owner`.
  - Outputs a one-hot and an index; instantiated once.

## Test plan
- Single SHA-256 job: req[0] with mlen=64, olen=32, using a wrapper model that raises done 120 cycles after core_rst falls.
  - → gnt[0] at t+1; core_rst low at t+2; job_done[0] exactly once; release → IDLE.
- req[0] and req[2] raised in the same cycle, both released after done.
  - → order 0, 2.
  - Then req[0] and req[1] → order 1, 0 (circular fairness).
- SHAKE128, olen=168, then req_more with olen=168 twice.
  - → each round shows core_intermediate_rst and core_next_extract in consecutive cycles, then ARM; three job_done pulses total.
- req_more and req_release asserted together in HOLD.
  - → IDLE with no squeeze pulses.
  - Also req_more with rate_type=1 → ignored; state stays HOLD.
- rst_n low for 3 cycles during RUN.
  - → all outputs at reset values, including core_rst=1; no job_done; a new req is served normally afterwards.
- With SHA_SCHED_WATCHDOG_EN and WDOG_CYCLES=16, core_done held at 0.
  - → err=1 and job_done pulse 16 cycles after ARM entry, then IDLE.
  - err stays 1 across the next job until rst_n.
